// File: rtl/xor_maj_pkg.sv
// Shared helpers for the parity-then-vote pipeline: threshold defaults,
// field-width sizing and a population count.
package xor_maj_pkg;

  // Widest voter vector popcount() accepts; VOTE_N must not exceed this.
  localparam int unsigned POP_MAX_W = 64;

  function automatic int unsigned maj_thr(input int unsigned n);
    return (n + 1) / 2;
  endfunction

  // Width able to hold any count 0..n (threshold and popcount fields).
  function automatic int unsigned thr_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      c += 32'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/xor_maj_stage.sv
// Generic valid/ready register slice: accepts a new payload whenever it is
// empty or its current payload leaves in the same cycle.
module xor_maj_stage #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic load;

  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of the order blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      // NOTE: this is a single payload register, not a RAM, so clearing it on
      // reset is cheap and keeps the out_* ports at a defined 0 after reset.
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/xor_maj_pipe.sv
// Two-stage parity-then-threshold-vote pipeline with valid/ready flow control
// and a saturating count of asserted results.
module xor_maj_pipe
  import xor_maj_pkg::*;
#(
  parameter  int unsigned XOR_W  = 3,
  parameter  int unsigned VOTE_N = 3,
  parameter  int unsigned CNT_W  = 16,
  localparam int unsigned TW     = thr_width(VOTE_N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XOR_W-1:0]  in_xor,
  input  logic [VOTE_N-2:0] in_vote,
  input  logic [TW-1:0]     in_thr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_res,
  output logic              out_par,
  output logic [TW-1:0]     out_cnt,
  input  logic              clr,
  output logic [CNT_W-1:0]  hits
);

  localparam int unsigned SW = VOTE_N - 1;

  typedef struct packed {
    logic          par;
    logic [SW-1:0] side;
    logic [TW-1:0] thr_e;
  } s1_t;

  typedef struct packed {
    logic          res;
    logic          par;
    logic [TW-1:0] cnt;
  } s2_t;

  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  logic s1_valid;
  logic s2_ready;

  // NOTE: every always_comb output gets a full default first, so no path can
  // leave a field unassigned and infer a latch.
  always_comb begin
    s1_d       = '0;
    s1_d.par   = ^in_xor;
    s1_d.side  = in_vote;
    s1_d.thr_e = (in_thr == '0) ? TW'(maj_thr(VOTE_N)) : in_thr;
  end

  // Thresholds above VOTE_N can never be met, so they fall out as res=0.
  always_comb begin
    logic [TW-1:0] cnt;
    cnt      = TW'(popcount(POP_MAX_W'({s1_q.side, s1_q.par})));
    s2_d     = '0;
    s2_d.par = s1_q.par;
    s2_d.cnt = cnt;
    s2_d.res = (cnt >= s1_q.thr_e);
  end

  xor_maj_stage #(.W($bits(s1_t))) u_s1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (s1_d),
    .out_valid(s1_valid),
    .out_ready(s2_ready),
    .out_data (s1_q)
  );

  xor_maj_stage #(.W($bits(s2_t))) u_s2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (s1_valid),
    .in_ready (s2_ready),
    .in_data  (s2_d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (s2_q)
  );

  assign out_res = s2_q.res;
  assign out_par = s2_q.par;
  assign out_cnt = s2_q.cnt;

  // clr takes priority so software can zero the count without racing traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits <= '0;
    end else if (clr) begin
      hits <= '0;
    end else if (out_valid && out_ready && out_res && (hits != '1)) begin
      hits <= hits + 1'b1;
    end
  end

endmodule
